// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a show-ahead receive FIFO.
// Samples each bit at its nominal centre, counted from the first low sample of the start bit.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rd_en,
  input  logic       clear_err,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FullLast = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rxs;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic            frame_err_q, overrun_q;
  logic            half_hit, full_hit;
  logic            cnt_clr, bit_smp, push, ferr_set;

  logic [AW:0]     wptr_q, rptr_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            empty, full, do_push, do_pop, ovr_set;

  // Synchronizer idles high so a line held low through reset is a fresh start afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rxd};
  end
  assign rxs = sync_q[1];

  assign half_hit = (cnt_q == HalfLast);
  assign full_hit = (cnt_q == FullLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (!rxs) state_d = StStart;
      StStart: if (half_hit) state_d = rxs ? StIdle : StData;
      StData:  if (full_hit && idx_q == 3'd7) state_d = StStop;
      StStop:  if (full_hit) state_d = rxs ? StIdle : StBreak;
      StBreak: if (rxs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = (state_q != StIdle);
    cnt_clr  = 1'b1;
    bit_smp  = 1'b0;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      StStart: cnt_clr = half_hit;
      StData: begin
        cnt_clr = full_hit;
        bit_smp = full_hit;
      end
      StStop: begin
        cnt_clr  = full_hit;
        push     = full_hit & rxs;
        ferr_set = full_hit & ~rxs;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_clr ? '0 : cnt_q + CW'(1);
      frame_err_q <= ferr_set;
      if (state_q != StData) begin
        idx_q <= '0;
      end else if (bit_smp) begin
        idx_q          <= idx_q + 3'd1;
        shift_q[idx_q] <= rxs;
      end
    end
  end

  // FIFO: extra pointer MSB distinguishes full from empty.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = rd_en && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovr_set = push && full && !do_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
      if (ovr_set)        overrun_q <= 1'b1;
      else if (clear_err) overrun_q <= 1'b0;
    end
  end

  // When full with a simultaneous pop, the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= shift_q;
  end

  assign rd_valid  = !empty;
  assign rd_data   = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table-driven frames, timed corner cases, and
// randomized frames checked against a queue-based model of the receive path.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int unsigned N      = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int          BIT_NS = N * 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       rd_en = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, frame_err, overrun, busy;

  uart_rx_fifo #(.CLKS_PER_BIT(N), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rd_en(rd_en), .clear_err(clear_err),
    .rd_data(rd_data), .rd_valid(rd_valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int ferr_seen = 0;

  always @(negedge clk) if (frame_err) ferr_seen++;

  // Reference model: bytes the reader should see, and the sticky overrun flag.
  logic [7:0] q[$];
  bit         ov_m = 1'b0;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         pop_after;
    int         exp_ferr;
    bit         exp_valid;
    logic [7:0] exp_head;
    bit         exp_ovr;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int bit_ns);
    @(negedge clk);
    rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      #(bit_ns);
    end
    if (stop_ok) begin
      rxd = 1'b1;
      #(bit_ns);
    end else begin
      rxd = 1'b0;
      #(2 * bit_ns);
    end
    rxd = 1'b1;
    #(2 * bit_ns);
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  function automatic void model_rx(input logic [7:0] d, input bit stop_ok);
    if (stop_ok) begin
      if (q.size() < DEPTH) q.push_back(d);
      else ov_m = 1'b1;
    end
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, "_valid"}, rd_valid, q.size() != 0);
    if (q.size() != 0) chk({tag, "_head"}, rd_data, q[0]);
    chk({tag, "_ovr"}, overrun, ov_m);
  endtask

  // Waits for busy to rise; returns at the first negedge after t0.
  task automatic wait_busy(input string tag);
    int k = 0;
    while (!busy && k < 4 * N) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_busy_rise"}, busy, 1);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, rd_valid, 1);
    chk({tag, "_data"}, rd_data, exp);
    pop();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int f0;
    int j;
    int bit_ns;
    int npop;
    logic [7:0] d;
    bit stop_ok;

    vt[0]  = '{8'h34, 1'b1, 1'b1, 0, 1'b1, 8'h34, 1'b0};
    vt[1]  = '{8'h35, 1'b1, 1'b1, 0, 1'b1, 8'h35, 1'b0};
    vt[2]  = '{8'h2A, 1'b1, 1'b1, 0, 1'b1, 8'h2A, 1'b0};
    vt[3]  = '{8'h34, 1'b1, 1'b1, 0, 1'b1, 8'h34, 1'b0};
    vt[4]  = '{8'h32, 1'b1, 1'b1, 0, 1'b1, 8'h32, 1'b0};
    vt[5]  = '{8'h39, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b0};
    vt[6]  = '{8'h2F, 1'b1, 1'b1, 0, 1'b1, 8'h2F, 1'b0};
    vt[7]  = '{8'h30, 1'b1, 1'b0, 0, 1'b1, 8'h30, 1'b0};
    vt[8]  = '{8'h31, 1'b1, 1'b0, 0, 1'b1, 8'h30, 1'b0};
    vt[9]  = '{8'h32, 1'b1, 1'b0, 0, 1'b1, 8'h30, 1'b0};
    vt[10] = '{8'h33, 1'b1, 1'b0, 0, 1'b1, 8'h30, 1'b0};
    vt[11] = '{8'h34, 1'b1, 1'b0, 0, 1'b1, 8'h30, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Exact push timing: stop sample at t0 + N/2 + 9N
    fork
      send_frame(8'h34, 1'b1, BIT_NS);
      begin
        wait_busy("t1");
        repeat (N/2 + 9*N - 1) @(negedge clk);
        chk("t1_pre_push_valid", rd_valid, 0);
        @(negedge clk);
        chk("t1_push_valid", rd_valid, 1);
        chk("t1_push_data", rd_data, 8'h34);
        chk("t1_idle_after_stop", busy, 0);
      end
    join
    pop();
    chk("t1_pop_valid", rd_valid, 0);

    // Table-driven frames: stream, framing error, overflow
    for (int i = 0; i < 12; i++) begin
      f0 = ferr_seen;
      send_frame(vt[i].data, vt[i].stop_ok, BIT_NS);
      chk($sformatf("vec%0d_ferr", i), ferr_seen - f0, vt[i].exp_ferr);
      chk($sformatf("vec%0d_valid", i), rd_valid, vt[i].exp_valid);
      if (vt[i].exp_valid) chk($sformatf("vec%0d_head", i), rd_data, vt[i].exp_head);
      chk($sformatf("vec%0d_ovr", i), overrun, vt[i].exp_ovr);
      if (vt[i].pop_after) begin
        pop();
        chk($sformatf("vec%0d_after_pop", i), rd_valid, 0);
      end
    end
    pulse_clear();
    chk("clear_ovr", overrun, 0);

    // Push and pop in the same cycle while full
    fork
      send_frame(8'h5A, 1'b1, BIT_NS);
      begin
        wait_busy("pp");
        repeat (N/2 + 9*N - 1) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("pp_ovr", overrun, 0);
        chk("pp_head", rd_data, 8'h31);
      end
    join

    // Overrun set and clear_err in the same cycle: set wins
    fork
      send_frame(8'h77, 1'b1, BIT_NS);
      begin
        wait_busy("sc");
        repeat (N/2 + 9*N - 1) @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("sc_ovr", overrun, 1);
      end
    join
    pulse_clear();
    chk("sc_clear", overrun, 0);
    pop_expect("drain0", 8'h31);
    pop_expect("drain1", 8'h32);
    pop_expect("drain2", 8'h33);
    pop_expect("drain3", 8'h5A);
    chk("drain_empty", rd_valid, 0);
    pop();
    chk("pop_empty_valid", rd_valid, 0);
    chk("pop_empty_data", rd_data, 0);

    // Glitch shorter than half a bit
    f0 = ferr_seen;
    @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    chk("gl_busy_high", busy, 1);
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (N/2 + 3 - 5) @(negedge clk);
    chk("gl_busy_low", busy, 0);
    repeat (2 * N) @(negedge clk);
    chk("gl_no_byte", rd_valid, 0);
    chk("gl_no_ferr", ferr_seen - f0, 0);

    // Randomized frames with +-3% bit period against the model
    for (int it = 0; it < 40; it++) begin
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 4) != 0);
      j       = int'($urandom_range(0, 60)) - 30;
      bit_ns  = (BIT_NS * (1000 + j)) / 1000;
      f0      = ferr_seen;
      model_rx(d, stop_ok);
      send_frame(d, stop_ok, bit_ns);
      chk($sformatf("rnd%0d_ferr", it), ferr_seen - f0, stop_ok ? 0 : 1);
      chk_model($sformatf("rnd%0d", it));
      npop = int'($urandom_range(0, 2));
      for (int p = 0; p < npop; p++) begin
        if (q.size() != 0) begin
          chk($sformatf("rnd%0d_pop%0d", it, p), rd_data, q[0]);
          void'(q.pop_front());
        end
        pop();
        chk_model($sformatf("rnd%0d_p%0d", it, p));
      end
      if (ov_m) begin
        pulse_clear();
        ov_m = 1'b0;
        chk($sformatf("rnd%0d_clr", it), overrun, 0);
      end
    end

    // Reset during bit 4 of 0x99 with a byte already buffered
    send_frame(8'h42, 1'b1, BIT_NS);
    @(negedge clk);
    rxd = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rxd = (i == 0 || i == 3);
      #(BIT_NS);
    end
    rxd = 1'b1;
    #(BIT_NS / 2 + 1);
    reset = 1'b1;
    #1;
    chk("mr_valid", rd_valid, 0);
    chk("mr_data", rd_data, 0);
    chk("mr_ferr", frame_err, 0);
    chk("mr_ovr", overrun, 0);
    chk("mr_busy", busy, 0);
    q.delete();
    ov_m = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #(2 * BIT_NS);
    f0 = ferr_seen;
    send_frame(8'h03, 1'b1, BIT_NS);
    chk("mr_rx_ferr", ferr_seen - f0, 0);
    pop_expect("mr_rx", 8'h03);
    chk("mr_once", rd_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
